// File: rtl/switch_conditioner.sv
// switch_conditioner: two-flop synchronizer plus per-bit debounce for the
// slide switches feeding the Tug-of-War light FSM. Also produces a one-cycle
// change pulse and a startup-valid flag.
module switch_conditioner #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_sw,
  output logic [WIDTH-1:0] SW,
  output logic             sw_changed,
  output logic             sw_valid
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int VW = $clog2(DEBOUNCE_CYCLES + 2);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  state_t          state_q [WIDTH];
  state_t          state_d [WIDTH];
  logic [CW-1:0]   cnt_q   [WIDTH];
  logic [CW-1:0]   cnt_d   [WIDTH];
  logic [CW-1:0]   cnt_inc;
  logic [WIDTH-1:0] sw_q;
  logic [WIDTH-1:0] sw_d;
  logic [WIDTH-1:0] strobe;

  logic [VW-1:0]   start_cnt;
  logic            valid_q;

  // Two-flop synchronizer bringing the asynchronous pin levels into clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_sw;
      s2 <= s1;
    end
  end

  // Per-bit debounce next-state: the count is the number of consecutive
  // cycles s2 has disagreed with SW, so the bit flips on the edge where that
  // count reaches DEBOUNCE_CYCLES (also covers DEBOUNCE_CYCLES == 1 from STABLE).
  always_comb begin
    sw_d    = sw_q;
    strobe  = '0;
    cnt_inc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (s2[i] != sw_q[i]) begin
        if (state_q[i] == STABLE) begin
          cnt_inc = CW'(1);
        end else begin
          cnt_inc = cnt_q[i] + CW'(1);
        end
        if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
          sw_d[i]    = ~sw_q[i];
          strobe[i]  = 1'b1;
          cnt_d[i]   = '0;
          state_d[i] = STABLE;
        end else begin
          cnt_d[i]   = cnt_inc;
          state_d[i] = PENDING;
        end
      end else begin
        cnt_d[i]   = '0;
        state_d[i] = STABLE;
      end
    end
  end

  // Debounce state, counters, output bits and the merged change pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      sw_q       <= '0;
      sw_changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sw_q       <= sw_d;
      sw_changed <= |strobe;
    end
  end

  // Startup window: valid rises on the (DEBOUNCE_CYCLES+2)-th edge out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_cnt <= '0;
      valid_q   <= 1'b0;
    end else if (!valid_q) begin
      if (start_cnt == VW'(DEBOUNCE_CYCLES + 1)) begin
        valid_q <= 1'b1;
      end else begin
        start_cnt <= start_cnt + VW'(1);
      end
    end
  end

  assign SW       = sw_q;
  assign sw_valid = valid_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed vectors for switch_conditioner with
// DEBOUNCE_CYCLES=4, WIDTH=2. Expected values are hand-derived from the
// 6-edge latency (sample edge plus five more).
module tb_switch_conditioner;

  logic       clk;
  logic       reset;
  logic [1:0] raw_sw;
  logic [1:0] SW;
  logic       sw_changed;
  logic       sw_valid;

  int errors;
  int checks;

  switch_conditioner #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_sw(raw_sw),
    .SW(SW),
    .sw_changed(sw_changed),
    .sw_valid(sw_valid)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs, then advance n rising edges; outputs settle 1 unit later.
  task automatic applyStimulus(input logic [1:0] r, input logic rs, input int n);
    raw_sw = r;
    reset  = rs;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    logic [3:0] bounce;
    errors = 0;
    checks = 0;
    raw_sw = 2'b11;
    reset  = 1'b1;

    // Reset held two edges with switches high
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b11, 1'b1, 1);
      checkOutput("rst_sw", SW, 0);
      checkOutput("rst_chg", sw_changed, 0);
      checkOutput("rst_valid", sw_valid, 0);
    end
    applyStimulus(2'b00, 1'b0, 5);
    checkOutput("valid_edge5", sw_valid, 0);
    applyStimulus(2'b00, 1'b0, 1);
    checkOutput("valid_edge6", sw_valid, 1);

    // Sub-threshold glitch on bit 1 (three samples high)
    applyStimulus(2'b10, 1'b0, 3);
    checkOutput("glitch_sw_during", SW, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(2'b00, 1'b0, 1);
      checkOutput("glitch_sw", SW, 0);
      checkOutput("glitch_chg", sw_changed, 0);
    end

    // Clean step 00 -> 01
    applyStimulus(2'b01, 1'b0, 5);
    checkOutput("step_sw_early", SW, 0);
    checkOutput("step_chg_early", sw_changed, 0);
    applyStimulus(2'b01, 1'b0, 1);
    checkOutput("step_sw", SW, 1);
    checkOutput("step_chg", sw_changed, 1);
    applyStimulus(2'b01, 1'b0, 1);
    checkOutput("step_chg_end", sw_changed, 0);
    checkOutput("step_sw_hold", SW, 1);

    // Reset while SW=01 clears it without a pulse
    applyStimulus(2'b00, 1'b1, 1);
    checkOutput("rst2_sw", SW, 0);
    checkOutput("rst2_chg", sw_changed, 0);
    applyStimulus(2'b00, 1'b1, 1);
    applyStimulus(2'b00, 1'b0, 2);

    // Bounce on bit 0, then settle high
    bounce = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      applyStimulus({1'b0, bounce[k]}, 1'b0, 1);
      checkOutput("bounce_sw", SW, 0);
      checkOutput("bounce_chg", sw_changed, 0);
    end
    applyStimulus(2'b01, 1'b0, 5);
    checkOutput("settle_sw_early", SW, 0);
    checkOutput("settle_chg_early", sw_changed, 0);
    applyStimulus(2'b01, 1'b0, 1);
    checkOutput("settle_sw", SW, 1);
    checkOutput("settle_chg", sw_changed, 1);
    applyStimulus(2'b01, 1'b0, 1);
    checkOutput("settle_chg_end", sw_changed, 0);

    // Simultaneous change 00 -> 11
    applyStimulus(2'b00, 1'b1, 1);
    applyStimulus(2'b00, 1'b0, 2);
    applyStimulus(2'b11, 1'b0, 5);
    checkOutput("both_sw_early", SW, 0);
    applyStimulus(2'b11, 1'b0, 1);
    checkOutput("both_sw", SW, 3);
    checkOutput("both_chg", sw_changed, 1);
    applyStimulus(2'b11, 1'b0, 1);
    checkOutput("both_chg_end", sw_changed, 0);
    checkOutput("both_sw_hold", SW, 3);

    // Reset in the middle of a pending count
    applyStimulus(2'b00, 1'b1, 1);
    applyStimulus(2'b00, 1'b0, 2);
    applyStimulus(2'b10, 1'b0, 3);
    checkOutput("mid_sw_pre", SW, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b10, 1'b1, 1);
      checkOutput("mid_rst_sw", SW, 0);
      checkOutput("mid_rst_chg", sw_changed, 0);
      checkOutput("mid_rst_valid", sw_valid, 0);
    end
    applyStimulus(2'b10, 1'b0, 5);
    checkOutput("mid_sw_early", SW, 0);
    checkOutput("mid_valid_early", sw_valid, 0);
    applyStimulus(2'b10, 1'b0, 1);
    checkOutput("mid_sw", SW, 2);
    checkOutput("mid_chg", sw_changed, 1);
    checkOutput("mid_valid", sw_valid, 1);
    applyStimulus(2'b10, 1'b0, 1);
    checkOutput("mid_chg_end", sw_changed, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
